// File: rtl/soc_board_ctrl.sv
// soc_board_ctrl: board-level glue for debounced push buttons, extended
// reset-request pulses and a power-on style SoC reset sequencer.
// Every asynchronous input passes through a two-flop synchroniser before use.
module soc_board_ctrl #(
    parameter int NUM_BTN         = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_REQ         = 3,
    parameter int PULSE_EXT       = 32,
    parameter int EDGE_RISING     = 1,
    parameter int POR_CYCLES      = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] req_pulse_o,
    input  logic               soc_rst_req_i,
    output logic               soc_rstn_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PLS_W = $clog2(PULSE_EXT + 1);
    localparam int POR_W = $clog2(POR_CYCLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PLS_W-1:0]   PLS_LOAD  = PLS_W'(PULSE_EXT);
    localparam logic [POR_W-1:0]   POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] BTN_POL   = (BTN_ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_IDLE  = (EDGE_RISING != 0) ? {NUM_REQ{1'b0}} : {NUM_REQ{1'b1}};

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } soc_state_t;

    // Synchroniser stages
    logic [NUM_BTN-1:0] btn_meta_r;
    logic [NUM_BTN-1:0] btn_sync_r;
    logic [NUM_REQ-1:0] req_meta_r;
    logic [NUM_REQ-1:0] req_sync_r;
    logic               soc_meta_r;
    logic               soc_sync_r;

    // Debounce state
    logic [DB_W-1:0]    db_cnt_r [NUM_BTN];
    logic [NUM_BTN-1:0] btn_r;
    logic [NUM_BTN-1:0] btn_press_r;

    // Request pulse state
    logic [NUM_REQ-1:0] req_hist_r;
    logic [NUM_REQ-1:0] req_edge_s;
    logic [PLS_W-1:0]   pulse_cnt_r [NUM_REQ];
    logic [NUM_REQ-1:0] req_pulse_r;

    // SoC reset sequencer state
    soc_state_t         soc_state_r;
    logic [POR_W-1:0]   por_cnt_r;
    logic               soc_rstn_r;

    // Two-flop synchronisers; button polarity is normalised before the first flop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta_r <= {NUM_BTN{1'b0}};
            btn_sync_r <= {NUM_BTN{1'b0}};
            req_meta_r <= {NUM_REQ{1'b0}};
            req_sync_r <= {NUM_REQ{1'b0}};
            soc_meta_r <= 1'b0;
            soc_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= btn_i ^ BTN_POL;
            btn_sync_r <= btn_meta_r;
            req_meta_r <= req_i;
            req_sync_r <= req_meta_r;
            soc_meta_r <= soc_rst_req_i;
            soc_sync_r <= soc_meta_r;
        end
    end

    // Per-button debounce: accept a new level only after it has been stable long enough
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_r       <= {NUM_BTN{1'b0}};
            btn_press_r <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync_r[i] != btn_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        btn_r[i]       <= btn_sync_r[i];
                        btn_press_r[i] <= btn_sync_r[i];
                        db_cnt_r[i]    <= {DB_W{1'b0}};
                    end else begin
                        btn_press_r[i] <= 1'b0;
                        db_cnt_r[i]    <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    btn_press_r[i] <= 1'b0;
                    db_cnt_r[i]    <= {DB_W{1'b0}};
                end
            end
        end
    end

    // Qualifying request edge: synchronised level against its one-cycle history
    always_comb begin
        req_edge_s = {NUM_REQ{1'b0}};
        if (EDGE_RISING != 0) begin
            req_edge_s = req_sync_r & ~req_hist_r;
        end else begin
            req_edge_s = ~req_sync_r & req_hist_r;
        end
    end

    // Pulse stretchers: an edge arms a fixed-length pulse; edges while armed are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_hist_r  <= REQ_IDLE;
            req_pulse_r <= {NUM_REQ{1'b0}};
            for (int j = 0; j < NUM_REQ; j++) begin
                pulse_cnt_r[j] <= {PLS_W{1'b0}};
            end
        end else begin
            req_hist_r <= req_sync_r;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (pulse_cnt_r[j] != {PLS_W{1'b0}}) begin
                    pulse_cnt_r[j] <= pulse_cnt_r[j] - PLS_W'(1);
                    req_pulse_r[j] <= (pulse_cnt_r[j] != PLS_W'(1));
                end else if (req_edge_s[j]) begin
                    pulse_cnt_r[j] <= PLS_LOAD;
                    req_pulse_r[j] <= 1'b1;
                end else begin
                    pulse_cnt_r[j] <= {PLS_W{1'b0}};
                    req_pulse_r[j] <= 1'b0;
                end
            end
        end
    end

    // SoC reset sequencer: hold while requested, then count out the release delay
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            soc_state_r <= ST_HOLD;
            por_cnt_r   <= {POR_W{1'b0}};
            soc_rstn_r  <= 1'b0;
        end else if (soc_sync_r) begin
            soc_state_r <= ST_HOLD;
            por_cnt_r   <= {POR_W{1'b0}};
            soc_rstn_r  <= 1'b0;
        end else begin
            case (soc_state_r)
                ST_HOLD: begin
                    soc_state_r <= ST_COUNT;
                    por_cnt_r   <= {POR_W{1'b0}};
                    soc_rstn_r  <= 1'b0;
                end
                ST_COUNT: begin
                    if (por_cnt_r == POR_LAST) begin
                        soc_state_r <= ST_RUN;
                        por_cnt_r   <= {POR_W{1'b0}};
                        soc_rstn_r  <= 1'b1;
                    end else begin
                        soc_state_r <= ST_COUNT;
                        por_cnt_r   <= por_cnt_r + POR_W'(1);
                        soc_rstn_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    soc_state_r <= ST_RUN;
                    por_cnt_r   <= {POR_W{1'b0}};
                    soc_rstn_r  <= 1'b1;
                end
                default: begin
                    soc_state_r <= ST_HOLD;
                    por_cnt_r   <= {POR_W{1'b0}};
                    soc_rstn_r  <= 1'b0;
                end
            endcase
        end
    end

    assign btn_o       = btn_r;
    assign btn_press_o = btn_press_r;
    assign req_pulse_o = req_pulse_r;
    assign soc_rstn_o  = soc_rstn_r;

endmodule
